// File: rtl/instruction_fetch_queue_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_queue_if
//
// Bundles the NanoRisc fetch unit's bus signals so the core and the fetch
// queue can be wired with a single port.
//
//   load_en / load_addr / load_data     : memory write port (core -> fetch)
//   run                                 : fetch enable (core -> fetch)
//   redirect / redirect_addr            : branch redirect (core -> fetch)
//   instr_ready                         : decode accepts head (core -> fetch)
//   instr_valid / instr / instr_addr    : head of prefetch queue (fetch -> core)
//   queue_count                         : prefetch occupancy (fetch -> core)
//   fault                               : sticky out-of-range fetch flag
//
// master = core / decode side, slave = fetch queue.
// ---------------------------------------------------------------------------
interface instruction_fetch_queue_if #(
  parameter int WIDTH       = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int QUEUE_DEPTH = 4
);
  localparam int CNT_WIDTH = $clog2(QUEUE_DEPTH) + 1;

  logic                  load_en;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [WIDTH-1:0]      load_data;
  logic                  run;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_addr;
  logic                  instr_ready;
  logic                  instr_valid;
  logic [WIDTH-1:0]      instr;
  logic [ADDR_WIDTH-1:0] instr_addr;
  logic [CNT_WIDTH-1:0]  queue_count;
  logic                  fault;

  modport master (
    output load_en, load_addr, load_data, run, redirect, redirect_addr, instr_ready,
    input  instr_valid, instr, instr_addr, queue_count, fault
  );

  modport slave (
    input  load_en, load_addr, load_data, run, redirect, redirect_addr, instr_ready,
    output instr_valid, instr, instr_addr, queue_count, fault
  );
endinterface

// File: rtl/instruction_fetch_queue.sv
// ---------------------------------------------------------------------------
// instruction_fetch_queue
//
// Instruction store plus autonomous fetch engine for NanoRisc. A DEPTH x WIDTH
// memory is written through the load port; while running, sequential words
// are fetched into a QUEUE_DEPTH-entry FIFO that the decode stage drains via
// a valid/ready handshake. A redirect flushes the FIFO and restarts fetch.
//
// Ports:
//   clock  : system clock, rising edge
//   reset  : asynchronous, active-high; clears control state (memory kept)
//   bus    : instruction_fetch_queue_if.slave (load, run, redirect,
//            handshake, head entry, occupancy, sticky fault)
//
// Parameters: DEPTH must be 1..2^ADDR_WIDTH, QUEUE_DEPTH a power of 2 >= 2.
// The interface instance must use the same WIDTH/ADDR_WIDTH/QUEUE_DEPTH.
// ---------------------------------------------------------------------------
module instruction_fetch_queue #(
  parameter int WIDTH       = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 256,
  parameter int QUEUE_DEPTH = 4
) (
  input logic                      clock,
  input logic                      reset,
  instruction_fetch_queue_if.slave bus
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);

  // One extra bit so DEPTH == 2^ADDR_WIDTH is representable and the
  // out-of-range test collapses to constant-false in that case.
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_W:0]      FULL_COUNT = (PTR_W+1)'(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic                  fault_q;

  logic [WIDTH-1:0]      mem    [DEPTH];
  logic [WIDTH-1:0]      q_data [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] q_addr [QUEUE_DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W:0]        count;

  logic                  pc_oob;
  logic                  load_hit;
  logic                  queue_valid;
  logic                  pop;
  logic                  push;
  logic                  fault_hit;

  assign pc_oob      = {1'b0, fetch_pc} >= DEPTH_EXT;
  assign load_hit    = bus.load_en && ({1'b0, bus.load_addr} < DEPTH_EXT);
  assign queue_valid = (count != '0);
  assign pop         = queue_valid && bus.instr_ready;

  // Instruction memory: no reset so a program survives a core reset.
  always_ff @(posedge clock) begin
    if (load_hit) begin
      mem[bus.load_addr] <= bus.load_data;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= HALT;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state. Redirect overrides everything and is the only way out
  // of FAULT short of reset.
  always_comb begin
    state_next = state;
    if (bus.redirect) begin
      state_next = bus.run ? FETCH : HALT;
    end else begin
      case (state)
        HALT:    if (bus.run) state_next = FETCH;
        FETCH: begin
          if (pc_oob) begin
            state_next = FAULT;
          end else if (!bus.run) begin
            state_next = HALT;
          end
        end
        FAULT:   state_next = FAULT;
        default: state_next = HALT;
      endcase
    end
  end

  // FSM outputs. A full queue may still accept a push when the head is
  // popped on the same edge, which keeps throughput at one per cycle.
  // A load in the same cycle steals the slot so the write wins.
  always_comb begin
    push      = 1'b0;
    fault_hit = 1'b0;
    if (state == FETCH && !bus.redirect) begin
      if (pc_oob) begin
        fault_hit = 1'b1;
      end else if (!bus.load_en && (count < FULL_COUNT || pop)) begin
        push = 1'b1;
      end
    end
  end

  // Fetch pointer and sticky fault flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc <= '0;
      fault_q  <= 1'b0;
    end else if (bus.redirect) begin
      fetch_pc <= bus.redirect_addr;
      fault_q  <= 1'b0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 1'b1;
      end
      if (fault_hit) begin
        fault_q <= 1'b1;
      end
    end
  end

  // Queue bookkeeping. A redirect empties the queue even if the consumer
  // popped in that same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Queue storage; contents are only observable through count, so no reset.
  always_ff @(posedge clock) begin
    if (push) begin
      q_data[wr_ptr] <= mem[fetch_pc];
      q_addr[wr_ptr] <= fetch_pc;
    end
  end

  assign bus.instr_valid = queue_valid;
  assign bus.instr       = queue_valid ? q_data[rd_ptr] : '0;
  assign bus.instr_addr  = queue_valid ? q_addr[rd_ptr] : '0;
  assign bus.queue_count = count;
  assign bus.fault       = fault_q;

endmodule

// File: doc/instruction_fetch_queue.md
# instruction_fetch_queue

Parametrised instruction store with a fetch engine and prefetch queue for NanoRisc. It holds DEPTH words of WIDTH bits and is loadable through a dedicated write port. While running, it autonomously fetches sequential instructions into a QUEUE_DEPTH-entry FIFO. The decode stage consumes instructions through a valid/ready handshake, and the core redirects fetch on branches.

## Interface
- WIDTH, 8: instruction width in bits.
- ADDR_WIDTH, 8: address width.
- DEPTH, 256: memory words; must satisfy 1 ≤ DEPTH ≤ 2^ADDR_WIDTH.
- QUEUE_DEPTH, 4: prefetch entries; must be a power of 2 and ≥ 2.
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears control state only.
- load_en  in  1  write load_data to memory at load_addr.
- load_addr  in  ADDR_WIDTH  write address.
- load_data  in  WIDTH  write data.
- run  in  1  enables fetching.
- redirect  in  1  flushes the queue and restarts fetch at redirect_addr.
- redirect_addr  in  ADDR_WIDTH  new fetch address.
- instr_ready  in  1  consumer accepts the head entry.
- instr_valid  out  1  queue non-empty.
- instr  out  WIDTH  head instruction.
- instr_addr  out  ADDR_WIDTH  address of head instruction.
- queue_count  out  clog2(QUEUE_DEPTH)+1  occupancy.
- fault  out  1  sticky; set when fetch reached an address ≥ DEPTH.

## Operation
- Memory array: DEPTH×WIDTH. It is not cleared by reset; contents survive reset.
- Memory writes: a write occurs on an edge with load_en=1 and load_addr < DEPTH. Out-of-range writes are ignored.
- Internal state: fetch_pc (ADDR_WIDTH bits) and an FSM with states HALT, FETCH and FAULT.
- Reset: state=HALT, fetch_pc=0, queue empty, fault=0.
- HALT→FETCH: when run=1 and redirect=0.
- FETCH→HALT: when run=0. Queued entries remain and drain normally.
- Issue condition: in FETCH, an issue occurs when load_en=0, redirect=0, and either queue_count < QUEUE_DEPTH or a pop occurs this cycle.
- Issue action: at the edge, {mem[fetch_pc], fetch_pc} is pushed into the queue and fetch_pc increments modulo 2^ADDR_WIDTH.
- Fault detection: in FETCH, if fetch_pc ≥ DEPTH, no push happens, state becomes FAULT and fault is set to 1. This is only possible when DEPTH < 2^ADDR_WIDTH. When DEPTH = 2^ADDR_WIDTH, fetch_pc wraps from max to 0 with no fault.
- load_en in FETCH: suppresses issue that cycle; the write has priority. Entries already queued are not updated, so stale data is possible and software must redirect after loading.
- Pop: occurs when instr_valid && instr_ready. Push and pop may occur on the same edge; occupancy is then unchanged.
- Redirect (any state):
  - The queue is emptied, regardless of any pop that cycle.
  - fetch_pc=redirect_addr and fault is cleared.
  - Next state is FETCH if run=1, otherwise HALT.
  - No issue occurs in the redirect cycle.
- Simultaneous load_en and redirect: both take effect.
- FAULT: exited only by redirect or reset. The queue continues to drain.

## Timing
- Reset values: instr_valid=0, instr=0, instr_addr=0, queue_count=0, fault=0.
- All outputs are registered or decoded from registered state. instr and instr_addr show the head entry, or 0 when the queue is empty.
- Startup latency: run rises before edge E → state becomes FETCH at E → first push at E+1 → instr_valid=1 after E+1.
- Throughput: one instruction per cycle with instr_ready held high.
- Redirect latency: redirect sampled at edge E → queue empty after E → push of redirect_addr at E+1 → valid after E+1.
- fault rises at the edge where fetch_pc ≥ DEPTH is sampled in FETCH.
- Reset asserted mid-operation immediately (asynchronously) forces all reset values. Memory contents are unchanged.

## Test plan
- Reset mid-fetch with 3 entries queued → all outputs 0 immediately. After release, mem[0..3] still reads back with run=1.
- Load 0xA1,0xB2,0xC3,0xD4 at addresses 0..3, then run=1 with ready=1 → (instr, instr_addr) = (A1,0), (B2,1), (C3,2), (D4,3) on consecutive cycles. First valid occurs 2 edges after run is sampled.
- Backpressure: ready=0 from start → queue_count saturates at 4 with entries 0..3, and no further issue occurs. Raise ready → addresses 0,1,2,3,4,5… appear with no gaps or duplicates.
- With 3 entries queued, pulse redirect with redirect_addr=0x10 and ready=1 → after that edge count=0 and valid=0. Next edge gives instr_addr=0x10; then 0x11 follows.
- DEPTH=200 instance, redirect to 198 → entries 198 and 199 are delivered, then fault=1 with no address 200 produced. Redirect to 0 → fault=0 and fetch resumes. DEPTH=256 instance, redirect to 255 → addresses 255, 0, 1 with fault=0.
- load_en=1 for one cycle during FETCH → no push that cycle, then the sequence continues. A load with load_addr=220 on a DEPTH=200 instance leaves memory unchanged.
